// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler
// ---------------------
// Builds one scanline of sprite pixels ahead of display. On line_start_i the
// attribute table is scanned from the highest index down to 0; each sprite
// that covers the requested line is fetched pixel by pixel from the shared
// sprite ROM and its opaque pixels are written into the prefetch line buffer.
// Because lower indices are drawn later, sprite 0 ends up on top.
//
// Optional feature: define LINE_CLEAR_EN to zero the whole line buffer
// (H_ACTIVE single-cycle writes) before the attribute scan starts.
//
// Ports
//   clk_i          system clock
//   reset_i        synchronous, active-low reset
//   line_start_i   one-cycle pulse: start building line next_line_i
//   next_line_i    scanline being prefetched, sampled on line_start_i
//   attr_addr_o    attribute table read index
//   attr_data_i    {dim[31:25], id[24:20], y[19:10], x[9:0]}, valid one
//                  cycle after attr_addr_o
//   rom_req_o      ROM read request (held until rom_ack_i)
//   rom_id_o       sprite id selecting the ROM
//   rom_addr_o     ROM word address (row stride 32 words)
//   rom_ack_i      rom_data_i valid; completes the request
//   rom_data_i     RGB pixel, 24'h0 is transparent
//   lb_we_o        line buffer write strobe
//   lb_addr_o      line buffer pixel index
//   lb_data_o      line buffer write data
//   busy_o         high from line_start_i until the scan is done
//   overrun_o      sticky: line_start_i arrived while busy
//   state_o        current FSM state (debug)
//
// Handshake: rom_req_o/rom_id_o/rom_addr_o stay stable from the FETCH cycle
// through every WAIT cycle; the request completes in the first WAIT cycle
// that sees rom_ack_i=1. Only one request is ever outstanding, and an ack
// seen in any other state is ignored.

module sprite_line_scheduler #(
    parameter int NUM_SPRITES = 8,
    parameter int MAX_DIM     = 32,
    parameter int H_ACTIVE    = 640,
    localparam int AW         = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          line_start_i,
    input  logic [9:0]    next_line_i,
    output logic [AW-1:0] attr_addr_o,
    input  logic [31:0]   attr_data_i,
    output logic          rom_req_o,
    output logic [4:0]    rom_id_o,
    output logic [9:0]    rom_addr_o,
    input  logic          rom_ack_i,
    input  logic [23:0]   rom_data_i,
    output logic          lb_we_o,
    output logic [9:0]    lb_addr_o,
    output logic [23:0]   lb_data_o,
    output logic          busy_o,
    output logic          overrun_o,
    output logic [2:0]    state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
`ifdef LINE_CLEAR_EN
        S_CLEAR = 3'd1,
`endif
        S_ATTR  = 3'd2,
        S_CHECK = 3'd3,
        S_FETCH = 3'd4,
        S_WAIT  = 3'd5,
        S_WRITE = 3'd6,
        S_NEXT  = 3'd7
    } state_t;

    state_t         state_q, state_d;
    logic [9:0]     line_q, line_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [9:0]     x_q, x_d;
    logic [4:0]     id_q, id_d;
    logic [5:0]     dim_q, dim_d;
    logic [4:0]     row_q, row_d;
    logic [5:0]     col_q, col_d;
    logic [23:0]    pix_q, pix_d;
    logic           overrun_q, overrun_d;
`ifdef LINE_CLEAR_EN
    logic [9:0]     clr_q, clr_d;
`endif

    // Attribute fields, decoded straight from the table read port in CHECK.
    logic [6:0]     a_dim;
    logic [4:0]     a_id;
    logic [9:0]     a_y;
    logic [9:0]     a_x;
    logic [6:0]     a_d;
    logic [10:0]    y_ext;
    logic [10:0]    l_ext;
    logic [10:0]    y_end;
    logic           hit;

    // Pixel column bookkeeping.
    logic [10:0]    xcol;
    logic [10:0]    xcol_inc;
    logic [5:0]     col_inc;
    logic [9:0]     fetch_addr;

    assign a_dim = attr_data_i[31:25];
    assign a_id  = attr_data_i[24:20];
    assign a_y   = attr_data_i[19:10];
    assign a_x   = attr_data_i[9:0];

    // Oversized sprites are clipped to MAX_DIM (which must fit in 6 bits).
    assign a_d   = (a_dim > 7'(MAX_DIM)) ? 7'(MAX_DIM) : a_dim;

    // 11-bit compare so y + d never wraps past line 1023.
    assign y_ext = {1'b0, a_y};
    assign l_ext = {1'b0, line_q};
    assign y_end = y_ext + {4'b0000, a_d};
    assign hit   = (a_d != 7'd0) && (l_ext >= y_ext) && (l_ext < y_end);

    assign xcol     = {1'b0, x_q} + {5'b00000, col_q};
    assign xcol_inc = xcol + 11'd1;
    assign col_inc  = col_q + 6'd1;

    // Row stride is 32 words; the sum wraps at 10 bits by design.
    assign fetch_addr = {row_q, 5'b00000} + {4'b0000, col_q};

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        idx_d       = idx_q;
        x_d         = x_q;
        id_d        = id_q;
        dim_d       = dim_q;
        row_d       = row_q;
        col_d       = col_q;
        pix_d       = pix_q;
        overrun_d   = overrun_q;
`ifdef LINE_CLEAR_EN
        clr_d       = clr_q;
`endif
        attr_addr_o = '0;
        rom_req_o   = 1'b0;
        rom_id_o    = 5'd0;
        rom_addr_o  = 10'd0;
        lb_we_o     = 1'b0;
        lb_addr_o   = 10'd0;
        lb_data_o   = 24'd0;

        case (state_q)
            S_IDLE: begin
            end

`ifdef LINE_CLEAR_EN
            S_CLEAR: begin
                lb_we_o   = 1'b1;
                lb_addr_o = clr_q;
                if (clr_q == 10'(H_ACTIVE - 1)) begin
                    state_d = S_ATTR;
                end else begin
                    clr_d = clr_q + 10'd1;
                end
            end
`endif

            S_ATTR: begin
                attr_addr_o = idx_q;
                state_d     = S_CHECK;
            end

            S_CHECK: begin
                x_d   = a_x;
                id_d  = a_id;
                dim_d = a_d[5:0];
                // L - y is below 32 on a hit, so the low 5 bits suffice.
                row_d = line_q[4:0] - a_y[4:0];
                col_d = 6'd0;
                state_d = hit ? S_FETCH : S_NEXT;
            end

            S_FETCH: begin
                rom_req_o  = 1'b1;
                rom_id_o   = id_q;
                rom_addr_o = fetch_addr;
                state_d    = S_WAIT;
            end

            S_WAIT: begin
                rom_req_o  = 1'b1;
                rom_id_o   = id_q;
                rom_addr_o = fetch_addr;
                if (rom_ack_i) begin
                    pix_d   = rom_data_i;
                    state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                // Transparent and off-screen pixels are dropped silently.
                if ((pix_q != 24'd0) && (xcol < 11'(H_ACTIVE))) begin
                    lb_we_o   = 1'b1;
                    lb_addr_o = xcol[9:0];
                    lb_data_o = pix_q;
                end
                col_d = col_inc;
                if ((col_inc == dim_q) || (xcol_inc >= 11'(H_ACTIVE))) begin
                    state_d = S_NEXT;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_NEXT: begin
                if (idx_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q - AW'(1);
                    state_d = S_ATTR;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new line always wins, including over the final NEXT; any
        // outstanding ROM request is abandoned because WAIT is left.
        if (line_start_i) begin
            if (state_q != S_IDLE) begin
                overrun_d = 1'b1;
            end
            line_d = next_line_i;
            idx_d  = AW'(NUM_SPRITES - 1);
`ifdef LINE_CLEAR_EN
            clr_d   = 10'd0;
            state_d = S_CLEAR;
`else
            state_d = S_ATTR;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= S_IDLE;
            line_q    <= 10'd0;
            idx_q     <= '0;
            x_q       <= 10'd0;
            id_q      <= 5'd0;
            dim_q     <= 6'd0;
            row_q     <= 5'd0;
            col_q     <= 6'd0;
            pix_q     <= 24'd0;
            overrun_q <= 1'b0;
`ifdef LINE_CLEAR_EN
            clr_q     <= 10'd0;
`endif
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            idx_q     <= idx_d;
            x_q       <= x_d;
            id_q      <= id_d;
            dim_q     <= dim_d;
            row_q     <= row_d;
            col_q     <= col_d;
            pix_q     <= pix_d;
            overrun_q <= overrun_d;
`ifdef LINE_CLEAR_EN
            clr_q     <= clr_d;
`endif
        end
    end

    assign busy_o    = (state_q != S_IDLE);
    assign overrun_o = overrun_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed testbench for sprite_line_scheduler: attribute table model,
// sprite ROM responder with programmable ack delay, line buffer monitor and
// request/write logs checked against hand-computed expectations.

module tb_sprite_line_scheduler;

  localparam int NS = 8;
  localparam int HA = 640;
  localparam int AW = 3;
  localparam int BUDGET = 3000;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          line_start;
  logic [9:0]    next_line;
  logic [AW-1:0] attr_addr;
  logic [31:0]   attr_data;
  logic          rom_req;
  logic [4:0]    rom_id;
  logic [9:0]    rom_addr;
  logic          rom_ack;
  logic [23:0]   rom_data;
  logic          lb_we;
  logic [9:0]    lb_addr;
  logic [23:0]   lb_data;
  logic          busy;
  logic          overrun;
  logic [2:0]    state;

  logic resp_ack;
  logic force_ack;
  assign rom_ack = resp_ack | force_ack;

  sprite_line_scheduler #(
    .NUM_SPRITES(NS),
    .MAX_DIM(32),
    .H_ACTIVE(HA)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_n),
    .line_start_i(line_start),
    .next_line_i(next_line),
    .attr_addr_o(attr_addr),
    .attr_data_i(attr_data),
    .rom_req_o(rom_req),
    .rom_id_o(rom_id),
    .rom_addr_o(rom_addr),
    .rom_ack_i(rom_ack),
    .rom_data_i(rom_data),
    .lb_we_o(lb_we),
    .lb_addr_o(lb_addr),
    .lb_data_o(lb_data),
    .busy_o(busy),
    .overrun_o(overrun),
    .state_o(state)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;

  logic [31:0] attr_tab [NS];
  logic [23:0] pix_by_id [32];
  logic [4:0]  zero_id;
  logic [9:0]  zero_addr;
  logic        zero_en;
  logic        rom_en;
  int          ack_delay;

  logic [31:0] req_addr_q[$];
  logic [31:0] req_id_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [23:0] lb_model [1024];
  int          hi_writes;
  int          clr_writes;
  int          first_req_clr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_attr(input int dim, input int id, input int y, input int x);
    logic [6:0] d7;
    logic [4:0] i5;
    logic [9:0] y10;
    logic [9:0] x10;
    d7 = 7'(dim);
    i5 = 5'(id);
    y10 = 10'(y);
    x10 = 10'(x);
    return {d7, i5, y10, x10};
  endfunction

  function automatic logic [23:0] rom_pix(input logic [4:0] id, input logic [9:0] addr);
    if (zero_en && id == zero_id && addr == zero_addr) return 24'h0;
    return pix_by_id[id];
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // ---------------- attribute table model (1-cycle read) ----------------
  logic [AW-1:0] attr_addr_s;
  initial begin
    attr_data = 32'd0;
    forever begin
      @(negedge clk);
      attr_addr_s = attr_addr;
      @(posedge clk);
      #1;
      attr_data = attr_tab[attr_addr_s];
    end
  end

  // ---------------- ROM responder ----------------
  initial begin
    resp_ack = 1'b0;
    rom_data = 24'd0;
    forever begin
      @(posedge clk);
      #1;
      resp_ack = 1'b0;
      if (rom_en && rom_req) begin
        req_addr_q.push_back(32'(rom_addr));
        req_id_q.push_back(32'(rom_id));
        if (first_req_clr < 0) first_req_clr = clr_writes;
        repeat (ack_delay) begin
          @(posedge clk);
          #1;
        end
        if (rom_req) begin
          resp_ack = 1'b1;
          rom_data = rom_pix(rom_id, rom_addr);
        end
      end
    end
  end

  // ---------------- line buffer monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (lb_we) begin
        if (lb_addr >= 10'(HA)) hi_writes++;
        if (lb_data != 24'd0) begin
          wr_addr_q.push_back(32'(lb_addr));
          wr_data_q.push_back(32'(lb_data));
          lb_model[lb_addr] = lb_data;
        end else begin
          clr_writes++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    req_addr_q.delete();
    req_id_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    for (int i = 0; i < 1024; i++) lb_model[i] = 24'd0;
    hi_writes = 0;
    clr_writes = 0;
    first_req_clr = -1;
  endtask

  task automatic empty_table();
    for (int i = 0; i < NS; i++) attr_tab[i] = mk_attr(0, 0, 0, 0);
    zero_en = 1'b0;
  endtask

  task automatic start_line(input int l);
    @(posedge clk);
    #1;
    line_start = 1'b1;
    next_line = 10'(l);
    @(posedge clk);
    #1;
    line_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_rom_req"}, 32'(rom_req), 32'd0);
    check_eq({tag, "_lb_we"}, 32'(lb_we), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_overrun"}, 32'(overrun), 32'd0);
    check_eq({tag, "_attr_addr"}, 32'(attr_addr), 32'd0);
    check_eq({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check_eq({tag, "_rom_id"}, 32'(rom_id), 32'd0);
    check_eq({tag, "_lb_addr"}, 32'(lb_addr), 32'd0);
    check_eq({tag, "_lb_data"}, 32'(lb_data), 32'd0);
    check_eq({tag, "_state"}, 32'(state), 32'(ST_IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int n;
    reset_n = 1'b0;
    line_start = 1'b0;
    next_line = 10'd0;
    force_ack = 1'b0;
    rom_en = 1'b1;
    ack_delay = 1;
    zero_id = 5'd0;
    zero_addr = 10'd0;
    zero_en = 1'b0;
    for (int i = 0; i < 32; i++) pix_by_id[i] = 24'h0;
    empty_table();
    clear_logs();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset_n = 1'b1;

    // reset in the middle of WAIT, then a stray ack
    attr_tab[0] = mk_attr(4, 2, 10, 100);
    pix_by_id[2] = 24'hFF0000;
    rom_en = 1'b0;
    start_line(12);
    n = 0;
    while (state != ST_WAIT && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_wait", 32'(state), 32'(ST_WAIT));
    check_eq("wait_req", 32'(rom_req), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("rst_mid_wait");
    reset_n = 1'b1;
    force_ack = 1'b1;
    @(negedge clk);
    check_eq("stray_ack_we", 32'(lb_we), 32'd0);
    check_eq("stray_ack_state", 32'(state), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    @(negedge clk);
    check_eq("stray_ack_we2", 32'(lb_we), 32'd0);
    check_eq("stray_ack_busy", 32'(busy), 32'd0);
    rom_en = 1'b1;

    // single sprite, 4 pixels on row 2
    clear_logs();
    start_line(12);
    check_eq("s1_busy", 32'(busy), 32'd1);
    wait_idle("s1");
    check_eq("s1_nreq", 32'(req_addr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("s1_req_addr%0d", i), q_at(req_addr_q, i), 32'(64 + i));
      check_eq($sformatf("s1_req_id%0d", i), q_at(req_id_q, i), 32'd2);
    end
    check_eq("s1_nwr", 32'(wr_addr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("s1_wr_addr%0d", i), q_at(wr_addr_q, i), 32'(100 + i));
      check_eq($sformatf("s1_wr_data%0d", i), q_at(wr_data_q, i), 32'h00FF0000);
    end
    check_eq("s1_overrun", 32'(overrun), 32'd0);
`ifdef LINE_CLEAR_EN
    check_eq("s1_clear_before_req", 32'(first_req_clr), 32'(HA));
`endif

    // overlapping sprites: sprite 0 wins
    empty_table();
    attr_tab[1] = mk_attr(2, 1, 0, 50);
    attr_tab[0] = mk_attr(2, 0, 0, 50);
    pix_by_id[1] = 24'h00FF00;
    pix_by_id[0] = 24'h0000FF;
    clear_logs();
    start_line(0);
    wait_idle("prio");
    check_eq("prio_nreq", 32'(req_id_q.size()), 32'd4);
    check_eq("prio_first_id", q_at(req_id_q, 0), 32'd1);
    check_eq("prio_last_id", q_at(req_id_q, 3), 32'd0);
    check_eq("prio_addr1", q_at(req_addr_q, 1), 32'd1);
    check_eq("prio_px50", 32'(lb_model[50]), 32'h000000FF);
    check_eq("prio_px51", 32'(lb_model[51]), 32'h000000FF);
    check_eq("prio_nwr", 32'(wr_addr_q.size()), 32'd4);

    // right-edge clipping
    empty_table();
    attr_tab[0] = mk_attr(8, 3, 100, 638);
    pix_by_id[3] = 24'h123456;
    clear_logs();
    start_line(105);
    wait_idle("edge");
    check_eq("edge_nreq", 32'(req_addr_q.size()), 32'd2);
    check_eq("edge_req0", q_at(req_addr_q, 0), 32'd160);
    check_eq("edge_req1", q_at(req_addr_q, 1), 32'd161);
    check_eq("edge_nwr", 32'(wr_addr_q.size()), 32'd2);
    check_eq("edge_wr0", q_at(wr_addr_q, 0), 32'd638);
    check_eq("edge_wr1", q_at(wr_addr_q, 1), 32'd639);
    check_eq("edge_hi", 32'(hi_writes), 32'd0);

    // transparent pixel skipped, slow ROM
    empty_table();
    attr_tab[0] = mk_attr(4, 4, 0, 20);
    pix_by_id[4] = 24'hABCDEF;
    zero_en = 1'b1;
    zero_id = 5'd4;
    zero_addr = 10'd97;
    ack_delay = 3;
    clear_logs();
    start_line(3);
    wait_idle("transp");
    check_eq("transp_nreq", 32'(req_addr_q.size()), 32'd4);
    check_eq("transp_req3", q_at(req_addr_q, 3), 32'd99);
    check_eq("transp_nwr", 32'(wr_addr_q.size()), 32'd3);
    check_eq("transp_wr0", q_at(wr_addr_q, 0), 32'd20);
    check_eq("transp_wr1", q_at(wr_addr_q, 1), 32'd22);
    check_eq("transp_wr2", q_at(wr_addr_q, 2), 32'd23);
    check_eq("transp_px21", 32'(lb_model[21]), 32'd0);
    ack_delay = 1;

    // overrun: second line_start while busy restarts the scan
    empty_table();
    attr_tab[0] = mk_attr(4, 2, 10, 100);
    attr_tab[7] = mk_attr(2, 5, 200, 300);
    pix_by_id[5] = 24'h55AA55;
    clear_logs();
    start_line(12);
    repeat (3) @(posedge clk);
    #1;
    check_eq("ovr_busy_before", 32'(busy), 32'd1);
    clear_logs();
    start_line(201);
    check_eq("ovr_set", 32'(overrun), 32'd1);
    wait_idle("ovr");
    check_eq("ovr_sticky", 32'(overrun), 32'd1);
    check_eq("ovr_nreq", 32'(req_addr_q.size()), 32'd2);
    check_eq("ovr_req0", q_at(req_addr_q, 0), 32'd32);
    check_eq("ovr_req1", q_at(req_addr_q, 1), 32'd33);
    check_eq("ovr_id", q_at(req_id_q, 0), 32'd5);
    check_eq("ovr_nwr", 32'(wr_addr_q.size()), 32'd2);
    check_eq("ovr_wr0", q_at(wr_addr_q, 0), 32'd300);
    check_eq("ovr_wr1", q_at(wr_addr_q, 1), 32'd301);
    check_eq("ovr_px100", 32'(lb_model[100]), 32'd0);
`ifdef LINE_CLEAR_EN
    check_eq("ovr_clear_before_req", 32'(first_req_clr >= HA), 32'd1);
`endif

    // a clean line afterwards keeps the sticky flag
    clear_logs();
    start_line(12);
    wait_idle("post");
    check_eq("post_nwr", 32'(wr_addr_q.size()), 32'd4);
    check_eq("post_wr0", q_at(wr_addr_q, 0), 32'd100);
    check_eq("post_overrun", 32'(overrun), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline sequencer that fills the prefetch sprite line buffer one line ahead of display.
- On each line_start it scans the sprite attribute table and selects the sprites that intersect next_line. It fetches their pixels from the shared sprite ROM through a single req/ack port and writes the non-transparent pixels into the line buffer write port.
- Sits between the attribute registers, the sprite ROMs and the line buffers; the buffer-toggle/readout logic is unchanged.

Parameters:
- NUM_SPRITES, 8, number of attribute-table entries; index width AW = clog2(NUM_SPRITES).
- MAX_DIM, 32, maximum sprite width/height in pixels; ROM row stride is fixed at 32 words.
- H_ACTIVE, 640, visible pixels per line; line buffer depth.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- line_start  in  1  one-cycle pulse: begin building the line next_line.
- next_line  in  10  scanline being prefetched; sampled on line_start.
- attr_addr  out  AW  attribute table read index.
- attr_data  in  32  {dim[31:25], id[24:20], y[19:10], x[9:0]}; valid 1 cycle after attr_addr.
- rom_req  out  1  ROM read request.
- rom_id  out  5  sprite id selecting the ROM.
- rom_addr  out  10  ROM word address.
- rom_ack  in  1  rom_data valid; completes the request.
- rom_data  in  24  RGB pixel; 24'h0 is transparent.
- lb_we  out  1  line buffer write strobe.
- lb_addr  out  10  line buffer pixel index.
- lb_data  out  24  line buffer write data.
- busy  out  1  high from line_start until DONE.
- overrun  out  1  sticky: line_start arrived while busy.

Behaviour:
- Reset (reset==0 at posedge): state IDLE. rom_req, lb_we, busy and overrun are 0. attr_addr, rom_addr, rom_id, lb_addr and lb_data are 0.
- States: IDLE, CLEAR, ATTR, CHECK, FETCH, WAIT, WRITE, NEXT.
- IDLE: on line_start, latch next_line into L and set sprite index S=NUM_SPRITES-1. Go to CLEAR (or ATTR, see feature). busy=1.
- ATTR: drive attr_addr=S. Next cycle go to CHECK, which registers attr_data.
- CHECK: d = min(dim, MAX_DIM). Hit when d!=0 and y <= L < y+d, compared at 11 bits so there is no wrap.
  - Hit: row = L-y; col=0; go to FETCH.
  - Miss: go to NEXT.
- FETCH: rom_req=1, rom_id=id, rom_addr = col + (row<<5), truncated to 10 bits. Go to WAIT.
- WAIT: rom_req, rom_id and rom_addr are held stable until the cycle rom_ack=1. Only one request is outstanding at a time.
- On ack: capture rom_data and go to WRITE.
- WRITE: lb_we=1 for exactly one cycle, with lb_addr=x+col and lb_data=captured pixel, only when the pixel is non-zero and x+col < H_ACTIVE. Otherwise there is no write.
  - col++.
  - If col==d or x+col >= H_ACTIVE, go to NEXT. Else go to FETCH.
- NEXT: if S==0, go to IDLE with busy=0. Else S--, go to ATTR.
- Priority: sprites are processed from the highest index down, so a lower index overwrites a higher one (sprite 0 on top). Transparent pixels never overwrite.
- Latency per hit sprite: 3 cycles + per pixel (3 + ack delay). Per miss: 3 cycles.
- line_start while busy:
  - Set overrun=1. It clears only on reset.
  - Any pending request is abandoned: rom_req drops next cycle and a late rom_ack is ignored.
  - Restart from IDLE semantics with the new next_line.
- line_start and the final NEXT in the same cycle: the restart wins.
- rom_ack received while not in WAIT is ignored.

Optional Feature:
- LINE_CLEAR_EN defined: after line_start, CLEAR writes lb_data=0 to lb_addr 0..H_ACTIVE-1, one per cycle with lb_we=1, then goes to ATTR. This adds H_ACTIVE cycles.
- LINE_CLEAR_EN undefined: the CLEAR state is absent, IDLE goes directly to ATTR, and the buffer is not cleared.

Test Plan:
- Reset low 2 cycles mid-WAIT -> all outputs 0, state IDLE; a following rom_ack is ignored and lb_we stays 0.
- Sprite 0 = {dim 4, id 2, y 10, x 100}, others dim 0, next_line=12, ack after 1 cycle, data 24'hFF0000 -> 4 requests with rom_addr 64,65,66,67 and rom_id 2. Writes to lb_addr 100..103, then busy falls.
- Sprites 1 and 0 both at x 50, y 0, dim 2, L=0, data 24'h00FF00 for id1 and 24'h0000FF for id0 -> sprite 1 fetched first; final lb_data at addr 50/51 is 24'h0000FF.
- Sprite x 638, dim 8, L within -> only 2 fetches, writes at 638 and 639; none at 640+.
- rom_data 24'h0 for col 1 of a 4-wide sprite at x 20 -> no write at 21; writes at 20, 22, 23.
- Second line_start 5 cycles after the first -> overrun=1 and stays 1, scan restarts with the new line. With LINE_CLEAR_EN: 640 zero writes precede the first rom_req.
